hc595_rx: RTL and testbench

Receive-side decoder for the 74HC595 seven-segment display link used by the watch. It is clocked in the system domain, oversamples the serial pins `ds`, `shcp`, `stcp` and `oe`, and emulates the cascaded shift and storage registers. Each latched segment/select frame is decoded back to a digit. When all six digit positions have been captured it rebuilds hours, minutes and seconds in binary. It sits at the far end of the display link: as a loopback monitor in the watch top level, and as the scoreboard front end in the display testbenches.

---
 rtl/hc595_pkg.sv | 39 +++
 rtl/seg7_decode.sv | 25 ++
 rtl/hc595_rx.sv | 103 ++++++++++
 tb/tb_hc595_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hc595_pkg.sv
// hc595_pkg: shared frame geometry, segment codes and decode helpers for the 74HC595 link
package hc595_pkg;

    localparam int FRAME_BITS = 14;
    localparam int SEG_W      = 8;
    localparam int SEL_W      = 6;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;

    function automatic logic [4:0] seg_decode(input logic [7:0] seg);
        case (seg | 8'h80)
            SEG_0:   return 5'h10;
            SEG_1:   return 5'h11;
            SEG_2:   return 5'h12;
            SEG_3:   return 5'h13;
            SEG_4:   return 5'h14;
            SEG_5:   return 5'h15;
            SEG_6:   return 5'h16;
            SEG_7:   return 5'h17;
            SEG_8:   return 5'h18;
            SEG_9:   return 5'h19;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic [7:0] bcd_pair(input logic [3:0] hi, input logic [3:0] lo);
        return 8'(hi) * 8'd10 + 8'(lo);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: maps an active-low segment byte and one-hot select to {valid, idx, nibble}
module seg7_decode
    import hc595_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    input  logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic [2:0]       idx,
    output logic [3:0]       nibble
);

    logic [4:0] code;
    logic       one_hot;

    // decode the digit code and the select position in one pass
    always_comb begin
        code    = seg_decode(seg);
        one_hot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
        idx     = '0;
        for (int i = 0; i < SEL_W; i++) idx = sel[i] ? 3'(i) : idx;
        valid   = code[4] && one_hot;
        nibble  = code[3:0];
    end

endmodule

// File: rtl/hc595_rx.sv
// hc595_rx: oversampling 74HC595 receiver that rebuilds hours/minutes/seconds from display frames
module hc595_rx #(
    parameter int FRAME_BITS  = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ds,
    input  logic       shcp,
    input  logic       stcp,
    input  logic       oe,
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       frame_valid,
    output logic       blank,
    output logic       err
);
    import hc595_pkg::*;

    logic [SYNC_STAGES-1:0][3:0] sync;
    logic [3:0]                  pins;
    logic                        ds_d, shcp_d, stcp_d;
    logic                        shift_en, latch_en;
    logic [FRAME_BITS-1:0]       sr, st;
    logic                        pend;
    logic [5:0][3:0]             digit;
    logic [5:0]                  seen;
    logic                        complete;
    logic                        dec_valid;
    logic [2:0]                  dec_idx;
    logic [3:0]                  dec_nib;

    assign pins     = sync[SYNC_STAGES-1];
    assign shift_en = pins[2] & ~shcp_d;
    assign latch_en = pins[1] & ~stcp_d;
    assign complete = seen == 6'h3F;

    // pin synchronizers plus one extra stage for edge detect; ds delayed alongside shcp
    always_ff @(posedge clk) begin
        if (rst) begin
            sync                   <= {SYNC_STAGES{4'b0001}};
            {ds_d, shcp_d, stcp_d} <= '0;
        end else begin
            sync                   <= {sync[SYNC_STAGES-2:0], {ds, shcp, stcp, oe}};
            {ds_d, shcp_d, stcp_d} <= pins[3:1];
        end
    end

    // shift and storage registers; a same-cycle latch captures the pre-shift sr
    always_ff @(posedge clk) begin
        if (rst) begin
            sr   <= '0;
            st   <= '0;
            pend <= 1'b0;
        end else begin
            if (shift_en) sr <= {sr[FRAME_BITS-2:0], ds_d};
            if (latch_en) st <= sr;
            pend <= latch_en;
        end
    end

    seg7_decode u_dec (
        .seg    (st[FRAME_BITS-1 -: SEG_W]),
        .sel    (st[SEL_W-1:0]),
        .valid  (dec_valid),
        .idx    (dec_idx),
        .nibble (dec_nib)
    );

    // decode stage and digit bank; a completed set is cleared while new captures still land
    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
            seen  <= '0;
            err   <= 1'b0;
        end else begin
            err  <= pend & ~dec_valid;
            if (pend && dec_valid) digit[dec_idx] <= dec_nib;
            seen <= (complete ? 6'h00 : seen) | ((pend && dec_valid) ? 6'b1 << dec_idx : 6'h00);
        end
    end

    // binary assembly once all six positions are present
    always_ff @(posedge clk) begin
        if (rst) begin
            hours       <= '0;
            minutes     <= '0;
            seconds     <= '0;
            frame_valid <= 1'b0;
            blank       <= 1'b1;
        end else begin
            frame_valid <= complete;
            blank       <= pins[0];
            if (complete) begin
                hours   <= bcd_pair(digit[5], digit[4]);
                minutes <= bcd_pair(digit[3], digit[2]);
                seconds <= bcd_pair(digit[1], digit[0]);
            end
        end
    end

endmodule

// File: tb/tb_hc595_rx.sv
// tb_hc595_rx: directed-vector bench for the 74HC595 receive decoder
module tb_hc595_rx;

    logic       clk, rst, ds, shcp, stcp, oe;
    logic [7:0] hours, minutes, seconds;
    logic       frame_valid, blank, err;
    int         tests, failed, fv_cnt, err_cnt, fv0, err0;
    logic [7:0] h_cap, m_cap, s_cap;

    localparam logic [7:0] SEGS [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    hc595_rx dut (
        .clk         (clk),
        .rst         (rst),
        .ds          (ds),
        .shcp        (shcp),
        .stcp        (stcp),
        .oe          (oe),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
        .frame_valid (frame_valid),
        .blank       (blank),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tally pulses and capture the time reported with each frame_valid
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt <= fv_cnt + 1;
            h_cap  <= hours;
            m_cap  <= minutes;
            s_cap  <= seconds;
        end
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        ds = b;
        tick(3);
        shcp = 1'b1;
        tick(3);
        shcp = 1'b0;
        tick(3);
    endtask

    task automatic shift_word(input logic [13:0] w);
        for (int i = 13; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic send_frame(input logic [7:0] seg, input logic [5:0] sel);
        shift_word({seg, sel});
        stcp = 1'b1;
        tick(3);
        stcp = 1'b0;
        tick(4);
    endtask

    initial begin
        rst = 1'b1; ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b1;
        tick(3);
        check("rst_hours", hours, 0);
        check("rst_min", minutes, 0);
        check("rst_sec", seconds, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_err", err, 0);
        check("rst_blank", blank, 1);
        rst = 1'b0;
        tick(3);

        shift_word({8'hA4, 6'b000001});
        stcp = 1'b1;
        tick(3);
        check("single_st", dut.st, 14'h2901);
        tick(1);
        check("single_seen", dut.seen, 6'h01);
        check("single_digit0", dut.digit[0], 2);
        check("single_err", err, 0);
        stcp = 1'b0;
        tick(4);

        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        check("rst_seen_clear", dut.seen, 0);
        fv0 = fv_cnt;
        err0 = err_cnt;
        send_frame(SEGS[1], 6'b100000);
        send_frame(SEGS[2], 6'b010000);
        send_frame(SEGS[3], 6'b001000);
        send_frame(SEGS[4], 6'b000100);
        send_frame(8'h12, 6'b000010);
        check("full_no_early_fv", fv_cnt - fv0, 0);
        shift_word({SEGS[6], 6'b000001});
        stcp = 1'b1;
        tick(5);
        check("full_fv", frame_valid, 1);
        check("full_hours", hours, 12);
        check("full_min", minutes, 34);
        check("full_sec", seconds, 56);
        check("full_seen_clr", dut.seen, 0);
        tick(1);
        check("full_fv_pulse", frame_valid, 0);
        stcp = 1'b0;
        tick(3);
        check("full_fv_count", fv_cnt - fv0, 1);
        check("full_no_err", err_cnt - err0, 0);

        shift_word({8'hFF, 6'b000100});
        stcp = 1'b1;
        tick(4);
        check("bad_seg_err", err, 1);
        check("bad_seg_seen", dut.seen, 0);
        tick(1);
        check("bad_seg_err_pulse", err, 0);
        stcp = 1'b0;
        tick(3);
        shift_word({8'hC0, 6'b000011});
        stcp = 1'b1;
        tick(4);
        check("bad_sel_err", err, 1);
        check("bad_sel_seen", dut.seen, 0);
        check("bad_sel_d0", dut.digit[0], 6);
        check("bad_sel_d1", dut.digit[1], 5);
        stcp = 1'b0;
        tick(4);

        shift_word(14'h2402);
        ds = 1'b1;
        tick(3);
        shcp = 1'b1;
        stcp = 1'b1;
        tick(3);
        check("simul_st", dut.st, 14'h2402);
        check("simul_sr", dut.sr, 14'h0805);
        tick(1);
        check("simul_seen", dut.seen, 6'h02);
        check("simul_err", err, 0);
        shcp = 1'b0;
        stcp = 1'b0;
        tick(4);

        oe = 1'b0;
        send_frame(SEGS[2], 6'b100000);
        send_frame(SEGS[3], 6'b010000);
        send_frame(SEGS[5], 6'b001000);
        check("mid_blank_low", blank, 0);
        check("mid_seen", dut.seen, 6'h3A);
        rst = 1'b1;
        tick(2);
        check("mid_rst_hours", hours, 0);
        check("mid_rst_min", minutes, 0);
        check("mid_rst_sec", seconds, 0);
        check("mid_rst_fv", frame_valid, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_blank", blank, 1);
        check("mid_rst_seen", dut.seen, 0);
        check("mid_rst_sr", dut.sr, 0);
        rst = 1'b0;
        tick(4);
        fv0 = fv_cnt;
        send_frame(SEGS[2], 6'b100000);
        send_frame(SEGS[3], 6'b010000);
        send_frame(SEGS[5], 6'b001000);
        send_frame(SEGS[9], 6'b000100);
        send_frame(SEGS[5], 6'b000010);
        send_frame(SEGS[9], 6'b000001);
        check("mid_fv_count", fv_cnt - fv0, 1);
        check("mid_hours", h_cap, 23);
        check("mid_min", m_cap, 59);
        check("mid_sec", s_cap, 59);

        fv0 = fv_cnt;
        send_frame(SEGS[3], 6'b000001);
        send_frame(SEGS[7], 6'b000001);
        send_frame(SEGS[2], 6'b000010);
        send_frame(SEGS[8], 6'b000100);
        send_frame(SEGS[4], 6'b001000);
        send_frame(SEGS[0], 6'b010000);
        check("ovr_no_early_fv", fv_cnt - fv0, 0);
        send_frame(SEGS[1], 6'b100000);
        check("ovr_fv_count", fv_cnt - fv0, 1);
        check("ovr_hours", h_cap, 10);
        check("ovr_min", m_cap, 48);
        check("ovr_sec", s_cap, 27);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
